// File: rtl/dtw_pkg.sv
// Shared types and width helpers for the DTW cost-matrix datapath.
// The distance cell and the DTW array both derive their widths from here.
package dtw_pkg;

    typedef enum logic [1:0] {
        ED_IDLE = 2'd0,
        ED_SUM  = 2'd1,
        ED_ROOT = 2'd2,
        ED_DONE = 2'd3
    } ed_state_t;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int unsigned v = 1; v < value; v = v << 1) begin
            r++;
        end
        return r;
    endfunction

    // Sum of NUM_F squares of (F_WIDTH+1)-bit magnitudes bounded by 2^F_WIDTH-1.
    function automatic int unsigned sum_width(input int unsigned num_f, input int unsigned f_width);
        return 2 * f_width + clog2(num_f);
    endfunction

    function automatic int unsigned root_width(input int unsigned sum_w);
        return (sum_w + 1) / 2;
    endfunction

    localparam int unsigned ED_NUM_F_DEF      = 8;
    localparam int unsigned ED_F_WIDTH_DEF    = 4;
    localparam int unsigned ED_SUM_WIDTH_DEF  = sum_width(ED_NUM_F_DEF, ED_F_WIDTH_DEF);
    localparam int unsigned ED_ROOT_WIDTH_DEF = root_width(ED_SUM_WIDTH_DEF);

endpackage

// File: rtl/isqrt_seq.sv
// Bit-serial restoring floor square root: one result bit per cycle, radicand MSB-first.
// done/root are combinational so the caller can commit the result on the final iteration edge.
module isqrt_seq
    import dtw_pkg::*;
#(
    parameter int unsigned IN_WIDTH = 11
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [IN_WIDTH-1:0]         radicand,
    output logic                        busy,
    output logic                        done,
    output logic [(IN_WIDTH+1)/2-1:0]   root
);
    localparam int unsigned OUT_W = (IN_WIDTH + 1) / 2;
    localparam int unsigned RAD_W = 2 * OUT_W;
    localparam int unsigned REM_W = OUT_W + 1;
    localparam int unsigned ACC_W = REM_W + 2;
    localparam int unsigned CNT_W = (OUT_W > 1) ? clog2(OUT_W) : 1;

    logic [RAD_W-1:0] rad_q, rad_d;
    logic [REM_W-1:0] rem_q, rem_d;
    logic [OUT_W-1:0] root_q, root_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic [ACC_W-1:0] acc_c, trial_c;

    always_comb begin
        rad_d   = rad_q;
        rem_d   = rem_q;
        root_d  = root_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        acc_c   = {rem_q, rad_q[RAD_W-1 -: 2]};
        trial_c = ACC_W'({root_q, 2'b01});
        if (start) begin
            rad_d  = RAD_W'(radicand);
            rem_d  = '0;
            root_d = '0;
            cnt_d  = CNT_W'(OUT_W - 1);
            busy_d = 1'b1;
        end else if (busy_q) begin
            rad_d = rad_q << 2;
            // Restore-free form: only commit the subtraction when it stays non-negative.
            if (acc_c >= trial_c) begin
                rem_d  = REM_W'(acc_c - trial_c);
                root_d = OUT_W'({root_q, 1'b1});
            end else begin
                rem_d  = REM_W'(acc_c);
                root_d = OUT_W'({root_q, 1'b0});
            end
            if (cnt_q == '0) begin
                busy_d = 1'b0;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rad_q  <= '0;
            rem_q  <= '0;
            root_q <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            rad_q  <= rad_d;
            rem_q  <= rem_d;
            root_q <= root_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;
    assign done = busy_q && (cnt_q == '0);
    assign root = root_d;

endmodule

// File: rtl/euclidean_distance_pipe.sv
// Handshaked Euclidean distance between two packed feature words for the DTW cost matrix.
// Squares are registered on accept, summed, then optionally reduced by the serial root engine.
module euclidean_distance_pipe
    import dtw_pkg::*;
#(
    parameter int unsigned NUM_F      = 8,
    parameter int unsigned F_WIDTH    = 4,
    parameter int unsigned F_SIGNED   = 1,
    parameter int unsigned SQRT_EN    = 1,
    parameter int unsigned N          = NUM_F * F_WIDTH,
    parameter int unsigned SUM_WIDTH  = sum_width(NUM_F, F_WIDTH),
    parameter int unsigned ROOT_WIDTH = root_width(SUM_WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N-1:0]         template_data,
    input  logic [N-1:0]         test_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SUM_WIDTH-1:0] out_data
);
    localparam int unsigned D_W  = F_WIDTH + 1;
    localparam int unsigned SQ_W = 2 * F_WIDTH;

    ed_state_t            state_q, state_d;
    logic [SQ_W-1:0]      sq_q [NUM_F];
    logic [SQ_W-1:0]      sq_d [NUM_F];
    logic [SQ_W-1:0]      sq_c [NUM_F];
    logic [SUM_WIDTH-1:0] sum_c;
    logic [SUM_WIDTH-1:0] out_data_q, out_data_d;
    logic                 in_ready_q, in_ready_d;
    logic                 out_valid_q, out_valid_d;
    logic                 root_start_c;
    logic                 root_busy;
    logic                 root_done;
    logic [SUM_WIDTH-1:0] result_c;

    // Per-feature squared difference of the words presented on the input port
    always_comb begin
        for (int k = 0; k < int'(NUM_F); k++) begin
            logic [F_WIDTH-1:0] t_f, s_f;
            logic [D_W-1:0]     t_x, s_x, diff, mag;
            t_f  = template_data[N-1-k*F_WIDTH -: F_WIDTH];
            s_f  = test_data[N-1-k*F_WIDTH -: F_WIDTH];
            t_x  = (F_SIGNED != 0) ? {t_f[F_WIDTH-1], t_f} : {1'b0, t_f};
            s_x  = (F_SIGNED != 0) ? {s_f[F_WIDTH-1], s_f} : {1'b0, s_f};
            diff = t_x - s_x;
            mag  = diff[D_W-1] ? D_W'(-diff) : diff;
            sq_c[k] = SQ_W'(SQ_W'(mag) * SQ_W'(mag));
        end
    end

    always_comb begin
        sum_c = '0;
        for (int k = 0; k < int'(NUM_F); k++) begin
            sum_c = sum_c + SUM_WIDTH'(sq_q[k]);
        end
    end

    always_comb begin
        state_d      = state_q;
        sq_d         = sq_q;
        out_data_d   = out_data_q;
        root_start_c = 1'b0;
        case (state_q)
            ED_IDLE: begin
                if (in_valid) begin
                    sq_d    = sq_c;
                    state_d = ED_SUM;
                end
            end
            ED_SUM: begin
                root_start_c = 1'b1;
                state_d      = ED_ROOT;
            end
            ED_ROOT: begin
                if (root_busy && root_done) begin
                    out_data_d = result_c;
                    state_d    = ED_DONE;
                end
            end
            ED_DONE: begin
                if (out_ready) begin
                    state_d = ED_IDLE;
                end
            end
            default: state_d = ED_IDLE;
        endcase
        in_ready_d  = (state_d == ED_IDLE);
        out_valid_d = (state_d == ED_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ED_IDLE;
            for (int k = 0; k < int'(NUM_F); k++) begin
                sq_q[k] <= '0;
            end
            out_data_q  <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sq_q        <= sq_d;
            out_data_q  <= out_data_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    if (SQRT_EN != 0) begin : g_root
        logic [ROOT_WIDTH-1:0] root_w;

        isqrt_seq #(
            .IN_WIDTH (SUM_WIDTH)
        ) u_isqrt (
            .clk      (clk),
            .rst_n    (rst_n),
            .start    (root_start_c),
            .radicand (sum_c),
            .busy     (root_busy),
            .done     (root_done),
            .root     (root_w)
        );

        assign result_c = SUM_WIDTH'(root_w);
    end else begin : g_bypass
        // Raw sum path: one register stage standing in for the root engine.
        logic [SUM_WIDTH-1:0] pass_q, pass_d;
        logic                 pend_q, pend_d;

        always_comb begin
            pass_d = pass_q;
            pend_d = root_start_c;
            if (root_start_c) begin
                pass_d = sum_c;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                pass_q <= '0;
                pend_q <= 1'b0;
            end else begin
                pass_q <= pass_d;
                pend_q <= pend_d;
            end
        end

        assign root_busy = pend_q;
        assign root_done = pend_q;
        assign result_c  = pass_q;
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_euclidean_distance_pipe.sv
// Bench for euclidean_distance_pipe: three configurations share one stimulus stream,
// each watched every cycle by a transaction-level model of the handshake and distance.
module tb_euclidean_distance_pipe;

    localparam int NI = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] template_data;
    logic [31:0] test_data;
    logic        in_ready_w  [NI];
    logic        out_valid_w [NI];
    logic [10:0] out_data_w  [NI];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Distance straight from the feature values: signed or unsigned nibbles, optional floor root.
    function automatic int ref_dist(input logic [31:0] t, input logic [31:0] s,
                                    input bit sgn, input bit sq);
        int sum, a, b, r;
        sum = 0;
        for (int k = 0; k < 8; k++) begin
            a = int'(t[31-4*k -: 4]);
            b = int'(s[31-4*k -: 4]);
            if (sgn) begin
                if (a > 7) a -= 16;
                if (b > 7) b -= 16;
            end
            sum += (a - b) * (a - b);
        end
        if (!sq) return sum;
        r = 0;
        while ((r + 1) * (r + 1) <= sum) r++;
        return r;
    endfunction

    function automatic logic [31:0] rnd_word();
        logic [31:0] w;
        logic [3:0]  f;
        w = '0;
        for (int k = 0; k < 8; k++) begin
            case ($urandom_range(0, 4))
                0: f = 4'h0;
                1: f = 4'h7;
                2: f = 4'h8;
                3: f = 4'hF;
                default: f = 4'($urandom);
            endcase
            w[31-4*k -: 4] = f;
        end
        return w;
    endfunction

    // g0: signed + root, g1: signed raw sum, g2: unsigned + root
    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int unsigned SG  = (g == 2) ? 0 : 1;
        localparam int unsigned SQ  = (g == 1) ? 0 : 1;
        localparam int          LAT = (SQ != 0) ? 7 : 2;

        euclidean_distance_pipe #(
            .NUM_F    (8),
            .F_WIDTH  (4),
            .F_SIGNED (SG),
            .SQRT_EN  (SQ)
        ) u_dut (
            .clk           (clk),
            .rst_n         (rst_n),
            .in_valid      (in_valid),
            .in_ready      (in_ready_w[g]),
            .template_data (template_data),
            .test_data     (test_data),
            .out_valid     (out_valid_w[g]),
            .out_ready     (out_ready),
            .out_data      (out_data_w[g])
        );

        bit busy_m = 1'b0;
        int k_m    = 0;
        int exp_m  = 0;

        always @(negedge clk) begin
            if (!rst_n) begin
                busy_m = 1'b0;
                chk($sformatf("g%0d reset in_ready", g), 64'(in_ready_w[g]), 64'd1);
                chk($sformatf("g%0d reset out_valid", g), 64'(out_valid_w[g]), 64'd0);
                chk($sformatf("g%0d reset out_data", g), 64'(out_data_w[g]), 64'd0);
            end else begin
                if (busy_m) k_m++;
                chk($sformatf("g%0d in_ready", g), 64'(in_ready_w[g]), 64'(!busy_m));
                chk($sformatf("g%0d out_valid", g), 64'(out_valid_w[g]), 64'(busy_m && k_m >= LAT));
                if (busy_m && k_m >= LAT)
                    chk($sformatf("g%0d out_data", g), 64'(out_data_w[g]), 64'(exp_m));
                if (!busy_m && in_valid) begin
                    busy_m = 1'b1;
                    k_m    = -1;
                    exp_m  = ref_dist(template_data, test_data, SG != 0, SQ != 0);
                end else if (busy_m && k_m >= LAT && out_ready) begin
                    busy_m = 1'b0;
                end
            end
        end
    end

    task automatic wait_ready();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (in_ready_w[0] && in_ready_w[1] && in_ready_w[2]) ok = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        chk("all in_ready within bound", 64'(ok), 64'd1);
    endtask

    task automatic accept(input logic [31:0] t, input logic [31:0] s);
        wait_ready();
        template_data = t;
        test_data     = s;
        in_valid      = 1'b1;
        @(posedge clk);
        #1;
        in_valid      = 1'b0;
    endtask

    task automatic run_vec(input logic [31:0] t, input logic [31:0] s,
                           input int e0, input int e1, input int e2);
        int exp_v [NI];
        int lat   [NI];
        bit seen  [NI];
        exp_v = '{e0, e1, e2};
        lat   = '{7, 2, 7};
        seen  = '{1'b0, 1'b0, 1'b0};
        out_ready = 1'b1;
        accept(t, s);
        for (int k = 0; k < 12; k++) begin
            for (int g = 0; g < NI; g++) begin
                if (out_valid_w[g] && !seen[g]) begin
                    seen[g] = 1'b1;
                    chk($sformatf("g%0d latency %h/%h", g, t, s), 64'(k), 64'(lat[g]));
                    chk($sformatf("g%0d result %h/%h", g, t, s), 64'(out_data_w[g]), 64'(exp_v[g]));
                end
            end
            @(posedge clk);
            #1;
        end
        for (int g = 0; g < NI; g++)
            chk($sformatf("g%0d result seen", g), 64'(seen[g]), 64'd1);
    endtask

    initial begin
        rst_n         = 1'b1;
        in_valid      = 1'b0;
        out_ready     = 1'b1;
        template_data = '0;
        test_data     = '0;
        #1 rst_n = 1'b0;

        // Hand-computed anchors for the reference model
        chk("model equal words", 64'(ref_dist(32'h1234ABCD, 32'h1234ABCD, 1, 1)), 64'd0);
        chk("model 7 vs -8 sum", 64'(ref_dist(32'h70000000, 32'h80000000, 1, 0)), 64'd225);
        chk("model 7 vs -8 root", 64'(ref_dist(32'h70000000, 32'h80000000, 1, 1)), 64'd15);
        chk("model all 7 vs -8 sum", 64'(ref_dist(32'h77777777, 32'h88888888, 1, 0)), 64'd1800);
        chk("model unsigned F vs 0", 64'(ref_dist(32'hFFFFFFFF, 32'h00000000, 0, 1)), 64'd42);
        chk("model 3-4-5", 64'(ref_dist(32'h34000000, 32'h00000000, 0, 1)), 64'd5);

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        run_vec(32'h1234ABCD, 32'h1234ABCD, 0, 0, 0);
        run_vec(32'h70000000, 32'h80000000, 15, 225, 1);
        run_vec(32'h77777777, 32'h88888888, 42, 1800, 2);
        run_vec(32'hFFFFFFFF, 32'h00000000, 2, 8, 42);
        run_vec(32'h34000000, 32'h00000000, 5, 25, 5);

        // Back-pressure: results held while new requests are presented and ignored
        out_ready = 1'b0;
        accept(32'h77777777, 32'h88888888);
        for (int i = 0; i < 15; i++) begin
            in_valid      = 1'b1;
            template_data = $urandom;
            test_data     = $urandom;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        chk("bp g0 out_data", 64'(out_data_w[0]), 64'd42);
        chk("bp g1 out_data", 64'(out_data_w[1]), 64'd1800);
        chk("bp g2 out_data", 64'(out_data_w[2]), 64'd2);
        for (int g = 0; g < NI; g++) begin
            chk($sformatf("bp g%0d out_valid held", g), 64'(out_valid_w[g]), 64'd1);
            chk($sformatf("bp g%0d in_ready low", g), 64'(in_ready_w[g]), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        for (int g = 0; g < NI; g++) begin
            chk($sformatf("release g%0d out_valid", g), 64'(out_valid_w[g]), 64'd0);
            chk($sformatf("release g%0d in_ready", g), 64'(in_ready_w[g]), 64'd1);
        end

        // Reset during the third root iteration cycle
        accept(32'h70000000, 32'h80000000);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        for (int g = 0; g < NI; g++) begin
            chk($sformatf("midreset g%0d out_valid", g), 64'(out_valid_w[g]), 64'd0);
            chk($sformatf("midreset g%0d out_data", g), 64'(out_data_w[g]), 64'd0);
            chk($sformatf("midreset g%0d in_ready", g), 64'(in_ready_w[g]), 64'd1);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        run_vec(32'h70000000, 32'h80000000, 15, 225, 1);

        // Random traffic with random back-pressure
        for (int i = 0; i < 3000; i++) begin
            in_valid      = ($urandom_range(0, 2) == 0);
            out_ready     = ($urandom_range(0, 3) != 0);
            template_data = rnd_word();
            test_data     = rnd_word();
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (20) @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
